// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, EX/MEM and MEM/WB operand forwarding,
// and load-use hazard detection against the instruction currently in ID.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   // ID side
   input  logic        in_valid,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic [15:0] imm,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   input  logic [4:0]  rd_addr,
   input  logic [1:0]  alu_op,
   input  logic [5:0]  funct,
   input  logic        alu_src,
   input  logic        reg_dst,
   input  logic        reg_write,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        mem_to_reg,
   // pipeline control
   input  logic        stall,
   input  logic        flush,
   // forwarding sources
   input  logic        exmem_reg_write,
   input  logic [4:0]  exmem_rd,
   input  logic [31:0] exmem_result,
   input  logic        memwb_reg_write,
   input  logic [4:0]  memwb_rd,
   input  logic [31:0] memwb_result,
   // ALU side
   output logic [31:0] A,
   output logic [31:0] B,
   output logic [2:0]  ALUoperation,
   output logic [31:0] store_data,
   // EX/MEM side
   output logic        out_valid,
   output logic [4:0]  write_reg,
   output logic        reg_write_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic        mem_to_reg_o,
   output logic        illegal_funct,
   // hazard
   output logic        hazard_stall
);

   typedef struct packed {
      logic       alu_src;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CtrlNone = '0;

   logic        valid_q;
   ctrl_t       ctrl_q;
   ctrl_t       ctrl_in;
   logic [31:0] rs_data_q;
   logic [31:0] rt_data_q;
   logic [31:0] imm_q;
   logic [4:0]  rs_addr_q;
   logic [4:0]  rt_addr_q;
   logic [4:0]  dest_q;
   logic [5:0]  funct_q;

   logic [31:0] imm_ext;
   logic [4:0]  dest_sel;
   logic [31:0] fwd_rs;
   logic [31:0] fwd_rt;
   logic        funct_bad;

   assign imm_ext  = {{16{imm[15]}}, imm};
   assign dest_sel = reg_dst ? rd_addr : rt_addr;

   always_comb begin
      ctrl_in.alu_src    = alu_src;
      ctrl_in.reg_write  = reg_write;
      ctrl_in.mem_read   = mem_read;
      ctrl_in.mem_write  = mem_write;
      ctrl_in.mem_to_reg = mem_to_reg;
      ctrl_in.alu_op     = alu_op;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         ctrl_q    <= CtrlNone;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         rs_addr_q <= '0;
         rt_addr_q <= '0;
         dest_q    <= '0;
         funct_q   <= '0;
      end else if (flush) begin
         // squash keeps data fields; only validity and controls matter downstream
         valid_q <= 1'b0;
         ctrl_q  <= CtrlNone;
      end else if (!stall) begin
         valid_q   <= in_valid;
         ctrl_q    <= in_valid ? ctrl_in : CtrlNone;
         rs_data_q <= rs_data;
         rt_data_q <= rt_data;
         imm_q     <= imm_ext;
         rs_addr_q <= rs_addr;
         rt_addr_q <= rt_addr;
         dest_q    <= dest_sel;
         funct_q   <= funct;
      end
   end

   // EX/MEM result is newer than MEM/WB, so it wins; register 0 is never forwarded
   always_comb begin
      fwd_rs = rs_data_q;
      if (exmem_reg_write && (exmem_rd == rs_addr_q) && (rs_addr_q != 5'd0)) begin
         fwd_rs = exmem_result;
      end else if (memwb_reg_write && (memwb_rd == rs_addr_q) && (rs_addr_q != 5'd0)) begin
         fwd_rs = memwb_result;
      end
   end

   always_comb begin
      fwd_rt = rt_data_q;
      if (exmem_reg_write && (exmem_rd == rt_addr_q) && (rt_addr_q != 5'd0)) begin
         fwd_rt = exmem_result;
      end else if (memwb_reg_write && (memwb_rd == rt_addr_q) && (rt_addr_q != 5'd0)) begin
         fwd_rt = memwb_result;
      end
   end

   always_comb begin
      ALUoperation = 3'b010;
      funct_bad    = 1'b0;
      case (ctrl_q.alu_op)
         2'b00: ALUoperation = 3'b010;
         2'b01: ALUoperation = 3'b110;
         2'b11: ALUoperation = 3'b111;
         default: begin
            case (funct_q)
               6'b100000: ALUoperation = 3'b010;
               6'b100010: ALUoperation = 3'b110;
               6'b100100: ALUoperation = 3'b000;
               6'b100101: ALUoperation = 3'b001;
               6'b101010: ALUoperation = 3'b111;
               default: begin
                  ALUoperation = 3'b010;
                  funct_bad    = 1'b1;
               end
            endcase
         end
      endcase
   end

   assign A             = fwd_rs;
   assign B             = ctrl_q.alu_src ? imm_q : fwd_rt;
   assign store_data    = fwd_rt;
   assign illegal_funct = valid_q & funct_bad;

   assign out_valid    = valid_q;
   assign write_reg    = dest_q;
   assign reg_write_o  = ctrl_q.reg_write;
   assign mem_read_o   = ctrl_q.mem_read;
   assign mem_write_o  = ctrl_q.mem_write;
   assign mem_to_reg_o = ctrl_q.mem_to_reg;

   // load in EX whose destination is read by the instruction sitting in ID
   assign hazard_stall = valid_q & ctrl_q.mem_read & (dest_q != 5'd0) & in_valid &
                         ((dest_q == rs_addr) | (dest_q == rt_addr));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for single-instruction behaviour and
// hand-written sequences for load-use stall, flush+stall and asynchronous reset.
module tb_id_ex_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] rs_data, rt_data;
   logic [15:0] imm;
   logic [4:0]  rs_addr, rt_addr, rd_addr;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
   logic        stall, flush;
   logic        exmem_reg_write, memwb_reg_write;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic [31:0] A, B, store_data;
   logic [2:0]  ALUoperation;
   logic        out_valid, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o;
   logic [4:0]  write_reg;
   logic        illegal_funct, hazard_stall;

   int tests = 0;
   int fails = 0;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .rs_data(rs_data), .rt_data(rt_data),
      .imm(imm), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .alu_op(alu_op),
      .funct(funct), .alu_src(alu_src), .reg_dst(reg_dst), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .stall(stall),
      .flush(flush), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
      .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
      .memwb_result(memwb_result), .A(A), .B(B), .ALUoperation(ALUoperation),
      .store_data(store_data), .out_valid(out_valid), .write_reg(write_reg),
      .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
      .mem_to_reg_o(mem_to_reg_o), .illegal_funct(illegal_funct), .hazard_stall(hazard_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ctl = {alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg}
   typedef struct {
      logic        in_valid;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [15:0] imm;
      logic [4:0]  rs_a;
      logic [4:0]  rt_a;
      logic [4:0]  rd_a;
      logic [1:0]  alu_op;
      logic [5:0]  funct;
      logic [5:0]  ctl;
      logic        ex_rw;
      logic [4:0]  ex_rd;
      logic [31:0] ex_res;
      logic        mw_rw;
      logic [4:0]  mw_rd;
      logic [31:0] mw_res;
      logic [31:0] e_a;
      logic [31:0] e_b;
      logic [2:0]  e_op;
      logic [31:0] e_sd;
      logic [4:0]  e_wr;
      logic        e_ov;
      logic        e_rw;
      logic        e_ill;
   } vec_t;

   localparam int NumVec = 10;
   vec_t vecs [NumVec];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      in_valid        = v.in_valid;
      rs_data         = v.rs_data;
      rt_data         = v.rt_data;
      imm             = v.imm;
      rs_addr         = v.rs_a;
      rt_addr         = v.rt_a;
      rd_addr         = v.rd_a;
      alu_op          = v.alu_op;
      funct           = v.funct;
      {alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg} = v.ctl;
      exmem_reg_write = v.ex_rw;
      exmem_rd        = v.ex_rd;
      exmem_result    = v.ex_res;
      memwb_reg_write = v.mw_rw;
      memwb_rd        = v.mw_rd;
      memwb_result    = v.mw_res;
   endtask

   task automatic clear_fwd();
      exmem_reg_write = 1'b0;
      exmem_rd        = 5'd0;
      exmem_result    = 32'h0;
      memwb_reg_write = 1'b0;
      memwb_rd        = 5'd0;
      memwb_result    = 32'h0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'd5, 32'd7, 16'h0, 5'd1, 5'd2, 5'd3, 2'b10, 6'h20, 6'b011000,
                  1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'd5, 32'd7, 3'b010, 32'd7, 5'd3, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 32'h99, 32'h33, 16'h0, 5'd4, 5'd6, 5'd7, 2'b10, 6'h22, 6'b011000,
                  1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22,
                  32'h11, 32'h33, 3'b110, 32'h33, 5'd7, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 32'h99, 32'h33, 16'h0, 5'd4, 5'd6, 5'd7, 2'b10, 6'h24, 6'b011000,
                  1'b0, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22,
                  32'h22, 32'h33, 3'b000, 32'h33, 5'd7, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 32'h55, 32'h44, 16'h0, 5'd0, 5'd8, 5'd9, 2'b10, 6'h25, 6'b011000,
                  1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'h1234,
                  32'h55, 32'h44, 3'b001, 32'h44, 5'd9, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 32'd3, 32'h77, 16'hFFFE, 5'd1, 5'd9, 5'd20, 2'b00, 6'h00, 6'b101000,
                  1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'd3, 32'hFFFF_FFFE, 3'b010, 32'h77, 5'd9, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 32'd1, 32'd5, 16'h0, 5'd11, 5'd10, 5'd12, 2'b10, 6'h2A, 6'b011000,
                  1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hABCD,
                  32'd1, 32'hABCD, 3'b111, 32'hABCD, 5'd12, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 32'd2, 32'd3, 16'h0, 5'd13, 5'd14, 5'd13, 2'b10, 6'h07, 6'b011000,
                  1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'd2, 32'd3, 3'b010, 32'd3, 5'd13, 1'b1, 1'b1, 1'b1};
      vecs[7] = '{1'b0, 32'd2, 32'd3, 16'h0, 5'd13, 5'd14, 5'd13, 2'b10, 6'h07, 6'b011000,
                  1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'd2, 32'd3, 3'b010, 32'd3, 5'd13, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{1'b1, 32'h100, 32'h200, 16'h0010, 5'd15, 5'd14, 5'd1, 2'b01, 6'h00,
                  6'b100010, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'h100, 32'h10, 3'b110, 32'h200, 5'd14, 1'b1, 1'b0, 1'b0};
      vecs[9] = '{1'b1, 32'd8, 32'd9, 16'h0, 5'd16, 5'd17, 5'd15, 2'b11, 6'h20, 6'b011000,
                  1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                  32'd8, 32'd9, 3'b111, 32'd9, 5'd15, 1'b1, 1'b1, 1'b0};

      // reset with stall/flush asserted: reset must win
      rst_n = 1'b0;
      stall = 1'b1;
      flush = 1'b1;
      drive(vecs[0]);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_A", A, 32'h0);
      chk("rst_B", B, 32'h0);
      chk("rst_aluop", 32'(ALUoperation), 32'd2);
      chk("rst_illegal", 32'(illegal_funct), 32'd0);
      chk("rst_hazard", 32'(hazard_stall), 32'd0);
      chk("rst_write_reg", 32'(write_reg), 32'd0);
      chk("rst_reg_write", 32'(reg_write_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stall = 1'b0;
      flush = 1'b0;

      for (int i = 0; i < NumVec; i++) begin
         drive(vecs[i]);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_A", i), A, vecs[i].e_a);
         chk($sformatf("vec%0d_B", i), B, vecs[i].e_b);
         chk($sformatf("vec%0d_aluop", i), 32'(ALUoperation), 32'(vecs[i].e_op));
         chk($sformatf("vec%0d_store_data", i), store_data, vecs[i].e_sd);
         chk($sformatf("vec%0d_write_reg", i), 32'(write_reg), 32'(vecs[i].e_wr));
         chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
         chk($sformatf("vec%0d_reg_write", i), 32'(reg_write_o), 32'(vecs[i].e_rw));
         chk($sformatf("vec%0d_illegal", i), 32'(illegal_funct), 32'(vecs[i].e_ill));
         @(negedge clk);
      end

      // load-use: lw $5, 4($1) enters EX
      clear_fwd();
      in_valid = 1'b1; rs_data = 32'h40; rt_data = 32'h0; imm = 16'd4;
      rs_addr = 5'd1; rt_addr = 5'd5; rd_addr = 5'd0; alu_op = 2'b00; funct = 6'h0;
      {alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg} = 6'b101101;
      @(posedge clk);
      #1;
      chk("lw_mem_read", 32'(mem_read_o), 32'd1);
      chk("lw_write_reg", 32'(write_reg), 32'd5);
      chk("lw_mem_to_reg", 32'(mem_to_reg_o), 32'd1);
      @(negedge clk);
      // add $7, $6, $5 in ID depends on the load
      rs_data = 32'h60; rt_data = 32'h61; imm = 16'h0;
      rs_addr = 5'd6; rt_addr = 5'd5; rd_addr = 5'd7; alu_op = 2'b10; funct = 6'h20;
      {alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg} = 6'b011000;
      #1;
      chk("luse_hazard", 32'(hazard_stall), 32'd1);
      in_valid = 1'b0;
      #1;
      chk("luse_hazard_noid", 32'(hazard_stall), 32'd0);
      in_valid = 1'b1;
      stall = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_A", A, 32'h40);
      chk("stall_B", B, 32'd4);
      chk("stall_write_reg", 32'(write_reg), 32'd5);
      chk("stall_mem_read", 32'(mem_read_o), 32'd1);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_hazard", 32'(hazard_stall), 32'd1);
      @(negedge clk);
      stall = 1'b0;
      @(posedge clk);
      #1;
      chk("release_write_reg", 32'(write_reg), 32'd7);
      chk("release_A", A, 32'h60);
      chk("release_B", B, 32'h61);
      chk("release_mem_read", 32'(mem_read_o), 32'd0);
      chk("release_hazard", 32'(hazard_stall), 32'd0);

      // flush and stall together must squash
      @(negedge clk);
      flush = 1'b1;
      stall = 1'b1;
      @(posedge clk);
      #1;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_reg_write", 32'(reg_write_o), 32'd0);
      chk("flush_illegal", 32'(illegal_funct), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      stall = 1'b0;
      @(posedge clk);
      #1;
      chk("reload_out_valid", 32'(out_valid), 32'd1);

      // asynchronous reset between edges clears outputs without a clock edge
      #2;
      rst_n = 1'b0;
      stall = 1'b1;
      flush = 1'b1;
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_A", A, 32'h0);
      chk("async_B", B, 32'h0);
      chk("async_write_reg", 32'(write_reg), 32'd0);
      chk("async_reg_write", 32'(reg_write_o), 32'd0);
      chk("async_aluop", 32'(ALUoperation), 32'd2);
      @(negedge clk);
      rst_n = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_out_valid", 32'(out_valid), 32'd1);
      chk("post_rst_write_reg", 32'(write_reg), 32'd7);
      chk("post_rst_A", A, 32'h60);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have these ports (name direction width meaning); clock and reset: clk in 1 rising-edge clock; rst_n in 1 asynchronous active-low reset.
REQ-002 The upstream ID side SHALL be: in_valid in 1 instruction present; rs_data, rt_data in 32 register-file reads; imm in 16 immediate; rs_addr, rt_addr, rd_addr in 5 each; alu_op in 2; funct in 6.
REQ-003 The ID control inputs SHALL be: alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg in 1 each.
REQ-004 The pipeline controls SHALL be: stall in 1 hold stage; flush in 1 squash stage.
REQ-005 The forwarding inputs SHALL be: exmem_reg_write in 1, exmem_rd in 5, exmem_result in 32, memwb_reg_write in 1, memwb_rd in 5, memwb_result in 32.
REQ-006 The ALU-side outputs SHALL be: A out 32 ALU operand A; B out 32 ALU operand B; ALUoperation out 3 ALU select; store_data out 32 forwarded rt value.
REQ-007 The EX/MEM-side outputs SHALL be: out_valid out 1; write_reg out 5; reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o out 1 each; illegal_funct out 1.
REQ-008 The hazard output SHALL be hazard_stall out 1, the load-use stall request to the front end.

Function
REQ-009 The stage SHALL register, on each rising clk edge: rs_data, rt_data, sign-extended imm (imm[15] replicated into bits 31:16), rs_addr, rt_addr, the selected destination, all control bits and in_valid.
REQ-010 The destination SHALL be rd_addr when reg_dst=1, else rt_addr; the result is registered and driven on write_reg.
REQ-011 Update priority SHALL be flush > stall > load.
- flush=1: out_valid<=0, all registered control bits <=0.
- stall=1 with flush=0: every register holds.
- Otherwise: load the inputs.
REQ-012 A load with in_valid=0 SHALL register a bubble: out_valid=0 and all control bits 0; data fields may load.
REQ-013 Latency SHALL be one cycle: an instruction accepted at edge N appears on all outputs after edge N.
REQ-014 ALUoperation SHALL be decoded combinationally from the registered alu_op/funct:
- alu_op 00 -> 010 (add)
- 01 -> 110 (sub)
- 11 -> 111 (slt)
- 10 -> funct 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111
- any other funct with alu_op 10 -> 010, and illegal_funct=1 when out_valid=1.
REQ-015 illegal_funct SHALL be 0 whenever out_valid=0 or alu_op is not 10.
REQ-016 Forwarded rs (fwd_rs) SHALL be computed combinationally from registered rs_addr (same rule for rt):
- exmem_result if exmem_reg_write=1, exmem_rd=rs_addr and rs_addr!=0;
- else memwb_result if memwb_reg_write=1, memwb_rd=rs_addr and rs_addr!=0;
- else registered rs_data.
REQ-017 EX/MEM forwarding SHALL take priority over MEM/WB when both match.
REQ-018 A SHALL equal fwd_rs, and store_data SHALL equal fwd_rt.
REQ-019 B SHALL equal the registered sign-extended imm when the registered alu_src=1, else fwd_rt.
REQ-020 Register 0 SHALL never be forwarded; the register-file value is used for register 0.
REQ-021 hazard_stall SHALL be 1 iff out_valid=1, mem_read_o=1, write_reg!=0, in_valid=1, and write_reg equals rs_addr or rt_addr on the inputs.
REQ-022 hazard_stall SHALL be purely combinational; the block SHALL NOT self-stall, since the external controller drives stall/flush.
REQ-023 Simultaneous flush and stall SHALL flush.
REQ-024 A, B, ALUoperation and store_data SHALL be driven even when out_valid=0; consumers qualify them with out_valid and the control bits.

Reset
REQ-025 While rst_n=0, all registers SHALL clear asynchronously and independently of clk: out_valid=0, control bits 0, write_reg=0, data/imm/address registers 0.
REQ-026 After reset, outputs SHALL therefore be A=0, B=0, ALUoperation=010, illegal_funct=0 and hazard_stall=0, unless forwarding inputs match register 0; by REQ-020 they never do.
REQ-027 Reset assertion mid-stall or mid-flush SHALL override both; the first load follows the first edge after rst_n deasserts.

Verification
REQ-028 The bench SHALL cover: reset then add $3,$1,$2 with rs_data=5, rt_data=7, alu_op=10, funct=100000 -> after one edge A=5, B=7, ALUoperation=010, write_reg=3, reg_write_o=1.
REQ-029 The bench SHALL cover: registered rs=4 with exmem(rw=1, rd=4, 0x11) and memwb(rw=1, rd=4, 0x22) -> A=0x11; exmem_reg_write dropped -> A=0x22.
REQ-030 The bench SHALL cover: registered rs=0, exmem_rd=0, exmem_reg_write=1, exmem_result=0xFFFF -> A=registered rs_data.
REQ-031 The bench SHALL cover: lw $5 in stage (mem_read_o=1, write_reg=5), input rt_addr=5, in_valid=1 -> hazard_stall=1; then stall=1 for one edge -> outputs unchanged.
REQ-032 The bench SHALL cover: addi with alu_src=1, imm=0xFFFE -> B=0xFFFFFFFE, ALUoperation=010.
REQ-033 The bench SHALL cover: flush and stall asserted together -> out_valid=0, reg_write_o=0; rst_n pulsed low between edges -> all outputs cleared immediately.
REQ-034 The bench SHALL cover: alu_op=10 with funct=000111 -> ALUoperation=010 and illegal_funct=1.
